// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, error codes, FSM states and signed operand limits for alu_accumulator
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_LOAD = 4'd8;
  localparam logic [3:0] OP_CLEAR = 4'd9;
  localparam logic [3:0] OP_NOP = 4'd15;
  localparam logic [1:0] ERR_OK = 2'b00;
  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_ALU = 2'b10;
  localparam logic [1:0] ERR_ILL = 2'b11;
  localparam int ALU_WIDTH = 16;
  localparam int SIGNED_MIN = -(1 << (ALU_WIDTH - 1));
  localparam int SIGNED_MAX = (1 << (ALU_WIDTH - 1)) - 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_accumulator.sv
// alu_accumulator: cmd handshake -> registered ALU drive -> settle -> capture into accumulator -> rsp handshake
module alu_accumulator
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RESULT_WIDTH = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_op,
  input  logic [WIDTH-1:0]        cmd_operand,
  output logic [WIDTH-1:0]        alu_input1,
  output logic [WIDTH-1:0]        alu_input2,
  output logic [3:0]              alu_op_code,
  input  logic [RESULT_WIDTH-1:0] alu_output1,
  input  logic [1:0]              alu_err_code,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [RESULT_WIDTH-1:0] rsp_acc,
  output logic [1:0]              rsp_err,
  output logic [1:0]              err_sticky
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  state_t r_state, w_next;
  logic [3:0] r_op;
  logic [WIDTH-1:0] r_in1, r_in2;
  logic [RESULT_WIDTH-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_err, r_sticky, w_local_err, w_cap_err;
  logic w_accept, w_is_alu, w_ovf, w_exec, w_capture;
  assign w_accept = r_state == IDLE && cmd_valid;
  assign w_is_alu = cmd_op <= OP_MOD;
  // acc fits the ALU operand width only if it equals the sign extension of its low WIDTH bits
  assign w_ovf = r_acc != {{(RESULT_WIDTH-WIDTH){r_acc[WIDTH-1]}}, r_acc[WIDTH-1:0]};
  assign w_exec = w_is_alu && !w_ovf;
  assign w_capture = r_state == EXEC && r_cnt == CW'(1);
  assign w_local_err = w_is_alu ? ERR_OVF :
                       (cmd_op == OP_LOAD || cmd_op == OP_CLEAR || cmd_op == OP_NOP) ? ERR_OK : ERR_ILL;
  assign w_cap_err = alu_err_code != 2'b00 ? ERR_ALU : ERR_OK;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state == IDLE ? (cmd_valid ? (w_exec ? EXEC : RESP) : IDLE) :
             r_state == EXEC ? (w_capture ? RESP : EXEC) :
             r_state == RESP ? (rsp_ready ? IDLE : RESP) : IDLE;
  end
  always_comb begin
    cmd_ready = r_state == IDLE;
    rsp_valid = r_state == RESP;
    alu_op_code = r_state == EXEC ? r_op : OP_NOP;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_op <= OP_NOP;
      r_in1 <= '0;
      r_in2 <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= ERR_OK;
      r_sticky <= ERR_OK;
    end else if (w_accept) begin
      r_op <= cmd_op;
      r_cnt <= CW'(SETTLE_CYCLES);
      if (w_exec) begin
        r_in1 <= r_acc[WIDTH-1:0];
        r_in2 <= cmd_operand;
      end else begin
        r_err <= w_local_err;
        r_sticky <= cmd_op == OP_CLEAR ? ERR_OK : r_sticky | w_local_err;
        r_acc <= cmd_op == OP_LOAD ? {{(RESULT_WIDTH-WIDTH){cmd_operand[WIDTH-1]}}, cmd_operand} :
                 cmd_op == OP_CLEAR ? '0 : r_acc;
      end
    end else if (r_state == EXEC) begin
      r_cnt <= r_cnt - CW'(1);
      if (w_capture) begin
        r_err <= w_cap_err;
        r_sticky <= r_sticky | w_cap_err;
        r_acc <= w_cap_err == ERR_OK ? alu_output1 : r_acc;
      end
    end
  assign alu_input1 = r_in1;
  assign alu_input2 = r_in2;
  assign rsp_acc = r_acc;
  assign rsp_err = r_err;
  assign err_sticky = r_sticky;
endmodule
